nonce_result_arbiter: RTL and testbench

Collects winning nonces from `NUM_CORES` parallel hash cores and serialises them, one at a time, onto a single-bit host output. Each core has a one-deep result slot. A round-robin arbiter picks the next pending slot, and a 32-cycle shift sequencer clocks that nonce out LSB-first under host `readready` flow control. It sits between the hash-core array and the host serial link, and replaces per-core output buffering.

---
 rtl/nonce_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/nonce_result_arbiter.sv | 127 ++++++++++++
 tb/tb_nonce_result_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_pkg.sv
// Shared widths and FSM state type for the nonce result arbiter.
package nonce_pkg;

    localparam int unsigned NONCE_W   = 32;
    localparam int unsigned BIT_CNT_W = 5;

    typedef enum logic {IDLE, SHIFT} arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N      = 4,
    parameter int unsigned CORE_W = $clog2(N)
) (
    input  logic [N-1:0]      req,
    input  logic [CORE_W-1:0] ptr,
    output logic              gnt_valid,
    output logic [CORE_W-1:0] gnt_idx
);

    logic [CORE_W-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        // Scan farthest offset first so the nearest request at/after ptr wins last.
        for (int i = N - 1; i >= 0; i--) begin
            idx = CORE_W'((int'(ptr) + i) % N);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/nonce_result_arbiter.sv
// Per-core one-deep result slots, round-robin selection and a 32-bit
// LSB-first serial shifter under host readready flow control.
module nonce_result_arbiter
    import nonce_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned CORE_W    = $clog2(NUM_CORES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CORES-1:0]         core_valid,
    input  logic [NUM_CORES-1:0]         core_success,
    input  logic [NUM_CORES*NONCE_W-1:0] core_nonce,
    input  logic                         readready,
    output logic                         nonce_o,
    output logic                         nonce_valid_o,
    output logic [CORE_W-1:0]            core_id_o,
    output logic [NUM_CORES-1:0]         pending_o,
    output logic [NUM_CORES-1:0]         overflow_o
);

    arb_state_t            state_q;
    logic [NONCE_W-1:0]    shift_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [CORE_W-1:0]     core_id_q;
    logic [CORE_W-1:0]     rr_ptr_q;
    logic [NONCE_W-1:0]    slot_q [NUM_CORES];

    logic [NUM_CORES-1:0]  pending_q, pending_d;
    logic [NUM_CORES-1:0]  overflow_q, overflow_d;
    logic [NUM_CORES-1:0]  capture, slot_we, grant_oh;
    logic                  gnt_valid;
    logic [CORE_W-1:0]     gnt_idx;

    assign capture = core_valid & core_success;

    rr_arbiter #(
        .N      (NUM_CORES),
        .CORE_W (CORE_W)
    ) u_rr_arbiter (
        .req       (pending_q),
        .ptr       (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        grant_oh = '0;
        if (state_q == IDLE && gnt_valid) begin
            grant_oh[gnt_idx] = 1'b1;
        end
    end

    // A slot being granted this edge has handed its value over, so it may refill.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        slot_we    = '0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (capture[i] && (!pending_q[i] || grant_oh[i])) begin
                slot_we[i]   = 1'b1;
                pending_d[i] = 1'b1;
            end else if (capture[i]) begin
                overflow_d[i] = 1'b1;
            end else if (grant_oh[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            overflow_q <= '0;
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                if (slot_we[i]) begin
                    slot_q[i] <= core_nonce[i*NONCE_W +: NONCE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            core_id_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        shift_q   <= slot_q[gnt_idx];
                        core_id_q <= gnt_idx;
                        rr_ptr_q  <= (gnt_idx == CORE_W'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (readready) begin
                        shift_q   <= {1'b0, shift_q[NONCE_W-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_CNT_W'(NONCE_W - 1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign nonce_o       = shift_q[0];
    assign nonce_valid_o = (state_q == SHIFT) && readready;
    assign core_id_o     = core_id_q;
    assign pending_o     = pending_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_nonce_result_arbiter.sv
// Scoreboard bench: stimulus queues expected frames, a monitor reassembles
// serial frames and compares them against the queue.
module tb_nonce_result_arbiter;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] nonce;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   core_valid = '0;
    logic [3:0]   core_success = '0;
    logic [127:0] core_nonce = '0;
    logic         readready = 1'b1;
    logic         nonce_o, nonce_valid_o;
    logic [1:0]   core_id_o;
    logic [3:0]   pending_o, overflow_o;

    nonce_result_arbiter #(
        .NUM_CORES (4),
        .CORE_W    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .core_valid    (core_valid),
        .core_success  (core_success),
        .core_nonce    (core_nonce),
        .readready     (readready),
        .nonce_o       (nonce_o),
        .nonce_valid_o (nonce_valid_o),
        .core_id_o     (core_id_o),
        .pending_o     (pending_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   start_q[$];
    int   end_q[$];
    int   frames_done = 0;
    int   bits_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: reassemble frames and compare against the scoreboard.
    logic [5:0]  bit_n = '0;
    logic [31:0] acc = '0;
    logic [1:0]  frame_id = '0;
    int          frame_start = 0;

    always @(negedge clk) begin
        if (rst) begin
            bit_n = '0;
        end else if (nonce_valid_o) begin
            bits_seen++;
            if (bit_n == 6'd0) begin
                frame_id    = core_id_o;
                frame_start = cyc + 1;
            end else begin
                chk("core_id_hold", 32'(core_id_o), 32'(frame_id));
            end
            acc[bit_n[4:0]] = nonce_o;
            bit_n = bit_n + 6'd1;
            if (bit_n == 6'd32) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame: got id %0d nonce %h, required no frame",
                             frame_id, acc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("frame_id", 32'(frame_id), 32'(e.id));
                    chk("frame_nonce", acc, e.nonce);
                end
                start_q.push_back(frame_start);
                end_q.push_back(cyc + 1);
                frames_done++;
                bit_n = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [3:0] mask, input logic [31:0] n0, input logic [31:0] n1,
                           input logic [31:0] n2, input logic [31:0] n3);
        core_valid   = mask;
        core_success = mask;
        core_nonce   = {n3, n2, n1, n0};
        tick();
        core_valid   = '0;
        core_success = '0;
    endtask

    task automatic expect_frame(input logic [1:0] id, input logic [31:0] n);
        exp_t e;
        e.id    = id;
        e.nonce = n;
        exp_q.push_back(e);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k;
        k = 0;
        while (frames_done < target && k < budget) begin
            tick();
            k++;
        end
        chk("frame_count", 32'(frames_done), 32'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        start_q.delete();
        end_q.delete();
    endtask

    task automatic chk_gap(input string name, input int a, input int b);
        chk(name, 32'(start_q.size() > b ? start_q[b] : -1),
            32'(end_q.size() > a ? end_q[a] + 2 : -2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no summary by time limit, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cap_edge, k, bits0;

        do_reset();
        chk("rst_nonce", 32'(nonce_o), 32'd0);
        chk("rst_valid", 32'(nonce_valid_o), 32'd0);
        chk("rst_core_id", 32'(core_id_o), 32'd0);
        chk("rst_pending", 32'(pending_o), 32'd0);
        chk("rst_overflow", 32'(overflow_o), 32'd0);

        // Valid without success must not capture.
        core_valid = 4'b0010;
        tick();
        core_valid = '0;
        chk("no_success", 32'(pending_o), 32'd0);

        // Single result from core 2.
        base = frames_done;
        expect_frame(2'd2, 32'hDEADBEEF);
        capture(4'b0100, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0);
        cap_edge = cyc;
        chk("t1_pending", 32'(pending_o), 32'h4);
        tick();
        chk("t1_grant_id", 32'(core_id_o), 32'd2);
        chk("t1_pending_clr", 32'(pending_o), 32'h0);
        wait_frames(base + 1, 60);
        chk("t1_first_bit", 32'(start_q.size() > 0 ? start_q[0] : -1), 32'(cap_edge + 2));
        chk("t1_last_bit", 32'(end_q.size() > 0 ? end_q[0] : -1), 32'(cap_edge + 33));

        // Round robin from pointer 0: cores 0, 1, 3 back to back.
        do_reset();
        base = frames_done;
        expect_frame(2'd0, 32'h11111111);
        expect_frame(2'd1, 32'h22222222);
        expect_frame(2'd3, 32'h33333333);
        capture(4'b1011, 32'h11111111, 32'h22222222, 32'h0, 32'h33333333);
        wait_frames(base + 3, 150);
        chk_gap("t2_gap01", 0, 1);
        chk_gap("t2_gap13", 1, 2);

        // Serve core 1 to park the pointer at 2, then 3 must beat 0.
        base = frames_done;
        expect_frame(2'd1, 32'h44444444);
        capture(4'b0010, 32'h0, 32'h44444444, 32'h0, 32'h0);
        wait_frames(base + 1, 60);
        base = frames_done;
        expect_frame(2'd3, 32'h66666666);
        expect_frame(2'd0, 32'h55555555);
        capture(4'b1001, 32'h55555555, 32'h0, 32'h0, 32'h66666666);
        wait_frames(base + 2, 100);

        // Overflow: second core 1 result arrives while its slot is still pending.
        base = frames_done;
        expect_frame(2'd0, 32'h77777777);
        expect_frame(2'd1, 32'h00000001);
        capture(4'b0001, 32'h77777777, 32'h0, 32'h0, 32'h0);
        capture(4'b0010, 32'h0, 32'h00000001, 32'h0, 32'h0);
        capture(4'b0010, 32'h0, 32'h00000002, 32'h0, 32'h0);
        chk("t3_overflow", 32'(overflow_o), 32'h2);
        chk("t3_pending", 32'(pending_o), 32'h2);
        wait_frames(base + 2, 100);
        chk("t3_overflow_sticky", 32'(overflow_o), 32'h2);

        // Refill on the grant edge is not an overflow.
        base = frames_done;
        expect_frame(2'd0, 32'h0000000A);
        expect_frame(2'd0, 32'h0000000B);
        capture(4'b0001, 32'hA, 32'h0, 32'h0, 32'h0);
        capture(4'b0001, 32'hB, 32'h0, 32'h0, 32'h0);
        chk("t4_pending", 32'(pending_o), 32'h1);
        chk("t4_no_overflow", 32'(overflow_o), 32'h2);
        wait_frames(base + 2, 100);

        // Stall pattern 1,0,0,1 starting on the first SHIFT cycle: 64 cycles.
        do_reset();
        base = frames_done;
        expect_frame(2'd1, 32'h12345678);
        capture(4'b0010, 32'h0, 32'h12345678, 32'h0, 32'h0);
        tick();
        k = 0;
        while (frames_done < base + 1 && k < 100) begin
            readready = (k % 4 == 0) || (k % 4 == 3);
            #1;
            chk("t5_valid_mirror", 32'(nonce_valid_o), 32'(readready));
            tick();
            k++;
        end
        readready = 1'b1;
        chk("t5_cycles", 32'(k), 32'd64);
        chk("t5_span", 32'(end_q.size() > 0 ? end_q[0] - start_q[0] : -1), 32'd63);

        // Reset in the middle of a frame.
        base = frames_done;
        expect_frame(2'd3, 32'hCAFEF00D);
        capture(4'b1000, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D);
        capture(4'b0001, 32'h1, 32'h0, 32'h0, 32'h0);
        capture(4'b0001, 32'h2, 32'h0, 32'h0, 32'h0);
        chk("t6_overflow_pre", 32'(overflow_o), 32'h1);
        k = 0;
        while (bit_n < 6'd10 && k < 40) begin
            tick();
            k++;
        end
        chk("t6_reached_bit10", 32'(bit_n), 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("t6_nonce", 32'(nonce_o), 32'd0);
        chk("t6_valid", 32'(nonce_valid_o), 32'd0);
        chk("t6_core_id", 32'(core_id_o), 32'd0);
        chk("t6_pending", 32'(pending_o), 32'd0);
        chk("t6_overflow", 32'(overflow_o), 32'd0);
        bits0 = bits_seen;
        repeat (40) tick();
        chk("t6_no_bits", 32'(bits_seen), 32'(bits0));
        chk("t6_frames", 32'(frames_done), 32'(base));

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
